reg16x16_wr_arb: RTL and testbench

Write-port arbiter and initialisation sequencer for the 16x16 register file `reg16x16`. It shares the register file's single write port between two requesters, A and B, using round-robin arbitration with a req/gnt handshake. On command it runs an init sweep that writes `INIT_VAL` to all 16 registers. It sits directly in front of `reg16x16` and drives its `wren`/`wrad`/`wrdt` inputs. The read ports are untouched.

---
 rtl/reg16x16_wr_arb.sv | 117 +++++++++++
 tb/tb_reg16x16_wr_arb.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reg16x16_wr_arb.sv
// Write-port arbiter and init sequencer in front of the reg16x16 register file.
// Two requesters share one write port by round-robin; an init sweep writes
// INIT_VAL to every register and takes priority over both requesters.
module reg16x16_wr_arb #(
    parameter int unsigned       DW       = 16,
    parameter int unsigned       AW       = 4,
    parameter logic [DW-1:0]     INIT_VAL = DW'(0)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          init_start,
    output logic          init_busy,
    input  logic          a_req,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_data,
    output logic          a_gnt,
    input  logic          b_req,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_data,
    output logic          b_gnt,
    output logic          wren,
    output logic [AW-1:0] wrad,
    output logic [DW-1:0] wrdt
);

    localparam int unsigned NREG = 1 << AW;
    // One extra bit so the counter can reach NREG and mark the closing cycle.
    localparam int unsigned CW   = AW + 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_INIT = 1'b1;

    logic [0:0]    state;
    logic [0:0]    state_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic          ptr_b;
    logic          ptr_b_nx;
    logic          wren_nx;
    logic [AW-1:0] wrad_nx;
    logic [DW-1:0] wrdt_nx;
    logic          busy_nx;

    // Next-state, grant and write-port selection.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        ptr_b_nx = ptr_b;
        wren_nx  = 1'b0;
        wrad_nx  = wrad;
        wrdt_nx  = wrdt;
        busy_nx  = init_busy;
        a_gnt    = 1'b0;
        b_gnt    = 1'b0;
        case (state)
            S_IDLE: begin
                if (init_start) begin
                    // First sweep write (address 0) goes out on the starting edge.
                    state_nx = S_INIT;
                    cnt_nx   = CW'(1);
                    wren_nx  = 1'b1;
                    wrad_nx  = '0;
                    wrdt_nx  = INIT_VAL;
                    busy_nx  = 1'b1;
                end else begin
                    a_gnt = reset & a_req & (~b_req | ~ptr_b);
                    b_gnt = reset & b_req & (~a_req | ptr_b);
                    if (a_gnt) begin
                        wren_nx  = 1'b1;
                        wrad_nx  = a_addr;
                        wrdt_nx  = a_data;
                        ptr_b_nx = 1'b1;
                    end else if (b_gnt) begin
                        wren_nx  = 1'b1;
                        wrad_nx  = b_addr;
                        wrdt_nx  = b_data;
                        ptr_b_nx = 1'b0;
                    end
                end
            end
            default: begin
                if (cnt == CW'(NREG)) begin
                    state_nx = S_IDLE;
                    cnt_nx   = '0;
                    busy_nx  = 1'b0;
                end else begin
                    wren_nx  = 1'b1;
                    wrad_nx  = cnt[AW-1:0];
                    wrdt_nx  = INIT_VAL;
                    cnt_nx   = cnt + CW'(1);
                end
            end
        endcase
    end

    // State, counter, pointer and registered write-port outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            ptr_b     <= 1'b0;
            wren      <= 1'b0;
            wrad      <= '0;
            wrdt      <= '0;
            init_busy <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            ptr_b     <= ptr_b_nx;
            wren      <= wren_nx;
            wrad      <= wrad_nx;
            wrdt      <= wrdt_nx;
            init_busy <= busy_nx;
        end
    end

endmodule

// File: tb/tb_reg16x16_wr_arb.sv
// Self-checking bench for reg16x16_wr_arb: directed cases plus random traffic
// compared every cycle against a queue-based behavioural model.
module tb_reg16x16_wr_arb;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 4;
    localparam logic [DW-1:0] IV = 16'h0000;

    logic          clk = 1'b0;
    logic          reset;
    logic          init_start;
    logic          init_busy;
    logic          a_req, b_req;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_data, b_data;
    logic          a_gnt, b_gnt;
    logic          wren;
    logic [AW-1:0] wrad;
    logic [DW-1:0] wrdt;

    reg16x16_wr_arb #(.DW(DW), .AW(AW), .INIT_VAL(IV)) dut (
        .clk(clk), .reset(reset), .init_start(init_start), .init_busy(init_busy),
        .a_req(a_req), .a_addr(a_addr), .a_data(a_data), .a_gnt(a_gnt),
        .b_req(b_req), .b_addr(b_addr), .b_data(b_data), .b_gnt(b_gnt),
        .wren(wren), .wrad(wrad), .wrdt(wrdt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: pending sweep writes live in a queue, grants follow
    // the round-robin rules whenever no sweep is in flight.
    bit            m_busy, m_wren, turn_b;
    logic [AW-1:0] m_wrad;
    logic [DW-1:0] m_wrdt;
    int            sweep_q[$];
    logic [DW-1:0] m_mem[16];
    logic [DW-1:0] d_mem[16];

    // Compare DUT against model mid-cycle, then advance the model across the next edge.
    always @(negedge clk) begin
        bit ea, eb, allowed;
        if (!reset) begin
            chk("rst_a_gnt", a_gnt, 0);
            chk("rst_b_gnt", b_gnt, 0);
            chk("rst_wren", wren, 0);
            chk("rst_wrad", wrad, 0);
            chk("rst_wrdt", wrdt, 0);
            chk("rst_busy", init_busy, 0);
            sweep_q.delete();
            m_busy = 0; m_wren = 0; turn_b = 0; m_wrad = '0; m_wrdt = '0;
        end else begin
            allowed = !m_busy;
            ea = allowed && !init_start && a_req && (!b_req || !turn_b);
            eb = allowed && !init_start && b_req && (!a_req || turn_b);
            chk("a_gnt", a_gnt, 32'(ea));
            chk("b_gnt", b_gnt, 32'(eb));
            chk("wren", wren, 32'(m_wren));
            chk("wrad", wrad, 32'(m_wrad));
            chk("wrdt", wrdt, 32'(m_wrdt));
            chk("busy", init_busy, 32'(m_busy));
            if (m_wren) m_mem[m_wrad] = m_wrdt;
            if (wren)   d_mem[wrad]   = wrdt;
            if (allowed && init_start)
                for (int i = 0; i < 16; i++) sweep_q.push_back(i);
            if (sweep_q.size() > 0) begin
                m_wrad = AW'(sweep_q.pop_front());
                m_wrdt = IV;
                m_wren = 1;
                m_busy = 1;
            end else begin
                m_busy = 0;
                m_wren = 0;
                if (ea) begin
                    m_wren = 1; m_wrad = a_addr; m_wrdt = a_data; turn_b = 1;
                end else if (eb) begin
                    m_wren = 1; m_wrad = b_addr; m_wrdt = b_data; turn_b = 0;
                end
            end
        end
    end

    // Values seen mid-cycle by the requesters.
    logic          sa, sb, sbusy, sw;
    logic [AW-1:0] swa;
    logic [DW-1:0] swd;

    task automatic tick();
        @(negedge clk);
        sa = a_gnt; sb = b_gnt; sbusy = init_busy; sw = wren; swa = wrad; swd = wrdt;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        int  n, ai, bi;
        bit  got, found;
        for (int i = 0; i < 16; i++) begin
            m_mem[i] = '0;
            d_mem[i] = '0;
        end
        reset = 1'b1; init_start = 0;
        a_req = 0; a_addr = '0; a_data = '0;
        b_req = 0; b_addr = '0; b_data = '0;
        #1 reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;

        // Idle after reset release
        tick();
        chk("lit_rst_wren", sw, 0);
        chk("lit_rst_wrad", swa, 0);
        chk("lit_rst_wrdt", swd, 0);
        chk("lit_rst_busy", sbusy, 0);
        chk("lit_rst_gnt", {sa, sb}, 0);

        // Single A write
        a_req = 1; a_addr = 4'h5; a_data = 16'hFEDC;
        tick();
        chk("lit_a_gnt", sa, 1);
        a_req = 0;
        tick();
        chk("lit_a_wren", sw, 1);
        chk("lit_a_wrad", swa, 5);
        chk("lit_a_wrdt", swd, 16'hFEDC);

        // Continuous A and B: strict alternation starting with A
        do_reset();
        ai = 0; bi = 0;
        a_req = 1; a_addr = 4'h0;  a_data = 16'hFE00;
        b_req = 1; b_addr = 4'hF;  b_data = 16'hBE00;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("lit_alt_a", sa, 32'(k % 2 == 0));
            chk("lit_alt_b", sb, 32'(k % 2 == 1));
            if (sa) begin ai++; a_addr = AW'(ai);      a_data = 16'hFE00 + 16'(ai); end
            if (sb) begin bi++; b_addr = AW'(15 - bi); b_data = 16'hBE00 + 16'(bi); end
        end
        a_req = 0; b_req = 0;
        tick();

        // Init sweep with A waiting
        a_req = 1; a_addr = 4'h9; a_data = 16'h1234; init_start = 1;
        tick();
        chk("lit_init_a_blocked", sa, 0);
        init_start = 0;
        n = 0; got = 0;
        for (int c = 0; c < 40 && !got; c++) begin
            tick();
            if (sa) got = 1;
            else if (sbusy) n++;
        end
        chk("lit_init_a_granted", got, 1);
        chk("lit_init_busy_len", n, 16);
        a_req = 0;
        tick();

        // Init and B in the same cycle; a second init_start mid-sweep is ignored
        b_req = 1; b_addr = 4'h3; b_data = 16'hBBBB; init_start = 1;
        tick();
        chk("lit_init_b_blocked", sb, 0);
        init_start = 0;
        n = 0; got = 0;
        for (int c = 0; c < 40 && !got; c++) begin
            tick();
            init_start = 0;
            if (sb) got = 1;
            else if (sbusy) begin
                n++;
                if (n == 5) init_start = 1;
            end
        end
        chk("lit_init_b_granted", got, 1);
        chk("lit_init_b_busy_len", n, 16);
        b_req = 0; init_start = 0;
        tick();

        // Reset mid-sweep at address 7
        init_start = 1;
        tick();
        init_start = 0;
        found = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (wren && wrad == 4'h7) begin
                found = 1;
                break;
            end
        end
        chk("lit_reach_wrad7", found, 1);
        #2 reset = 1'b0;
        #1;
        chk("lit_async_wren", wren, 0);
        chk("lit_async_wrad", wrad, 0);
        chk("lit_async_busy", init_busy, 0);
        @(posedge clk);
        #1;
        tick();
        reset = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("lit_no_resume", sw, 0);
        end

        // Random traffic under the request/grant handshake
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (!a_req || sa) begin
                a_req  = ($urandom % 3) != 0;
                a_addr = AW'($urandom);
                a_data = DW'($urandom);
            end
            if (!b_req || sb) begin
                b_req  = ($urandom % 3) != 0;
                b_addr = AW'($urandom);
                b_data = DW'($urandom);
            end
            init_start = ($urandom % 60) == 0;
            reset      = ($urandom % 400) != 0;
        end
        reset = 1'b1; init_start = 0; a_req = 0; b_req = 0;
        tick();
        tick();

        // Register file contents implied by the observed write port
        for (int i = 0; i < 16; i++) chk("mem", d_mem[i], m_mem[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
